// File: rtl/seg7_bus_display.sv
// Bus-mapped four-digit seven-segment controller: four CPU-visible registers
// and a guarded, time-multiplexed digit scan with registered pin outputs.
module seg7_bus_display #(
  parameter logic [7:0]  BASE_ADDR   = 8'hD0,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [3:0] DISP_SEL_OUT,
  output logic [7:0] DISP_OUT
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [1:0] OFS_DIG01  = 2'd0;
  localparam logic [1:0] OFS_DIG23  = 2'd1;
  localparam logic [1:0] OFS_DPMASK = 2'd2;
  localparam logic [1:0] OFS_CTRL   = 2'd3;

  typedef enum logic {
    SLOT_GUARD = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_t;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [7:0]       dig01;
  logic [7:0]       dig23;
  logic [3:0]       dp_mask;
  logic [4:0]       ctrl;
  logic             rd_en;
  logic [7:0]       rd_data;

  logic             in_win_c;
  logic [7:0]       reg_rdata_c;
  logic [3:0]       nibble_c;
  logic             show_c;
  slot_state_t      slot_state_c;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign in_win_c = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);

  always_comb begin
    reg_rdata_c = 8'h00;
    case (BUS_ADDR[1:0])
      OFS_DIG01:  reg_rdata_c = dig01;
      OFS_DIG23:  reg_rdata_c = dig23;
      OFS_DPMASK: reg_rdata_c = {4'h0, dp_mask};
      OFS_CTRL:   reg_rdata_c = {3'b000, ctrl};
      default:    reg_rdata_c = 8'h00;
    endcase
  end

  always_comb begin
    nibble_c = 4'h0;
    case (digit_idx)
      2'd0:    nibble_c = dig01[3:0];
      2'd1:    nibble_c = dig01[7:4];
      2'd2:    nibble_c = dig23[3:0];
      2'd3:    nibble_c = dig23[7:4];
      default: nibble_c = 4'h0;
    endcase
  end

  // The first count of every slot is a dark gap so the previous digit's
  // segments never bleed onto the newly selected anode.
  assign slot_state_c = (refresh_cnt == '0) ? SLOT_GUARD : SLOT_DRIVE;
  assign show_c = (slot_state_c == SLOT_DRIVE) && ctrl[4] && !ctrl[digit_idx];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      refresh_cnt  <= '0;
      digit_idx    <= 2'd0;
      dig01        <= 8'h00;
      dig23        <= 8'h00;
      dp_mask      <= 4'h0;
      ctrl         <= 5'h10;
      rd_en        <= 1'b0;
      rd_data      <= 8'h00;
      DISP_SEL_OUT <= 4'hF;
      DISP_OUT     <= 8'hFF;
    end else begin
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end

      if (BUS_WE && in_win_c) begin
        case (BUS_ADDR[1:0])
          OFS_DIG01:  dig01   <= BUS_DATA;
          OFS_DIG23:  dig23   <= BUS_DATA;
          OFS_DPMASK: dp_mask <= BUS_DATA[3:0];
          OFS_CTRL:   ctrl    <= BUS_DATA[4:0];
          default:    ;
        endcase
      end

      rd_en   <= !BUS_WE && in_win_c;
      rd_data <= reg_rdata_c;

      // Select and segments update together so they never mismatch.
      if (show_c) begin
        DISP_SEL_OUT <= ~(4'b0001 << digit_idx);
        DISP_OUT     <= {~dp_mask[digit_idx], hex_to_seg(nibble_c)};
      end else begin
        DISP_SEL_OUT <= 4'hF;
        DISP_OUT     <= 8'hFF;
      end
    end
  end

  assign BUS_DATA = rd_en ? rd_data : 8'bz;

endmodule
